// File: rtl/spi_chan_mux.sv
// SPI-slave command front end: frames mode-0 commands and queues channel-tagged pixel bytes in a
// first-word-fall-through FIFO, and holds the output-enable configuration and sticky error status.
module spi_chan_mux #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SYNC_STAGES  = 2,
    localparam int unsigned ChW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spi_nCS,
    input  logic                    spi_sck,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic [7:0]              out_data,
    output logic [ChW-1:0]          out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CHANNELS-1:0] out_en,
    output logic                    buffer_oe,
    output logic [2:0]              status
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StCfg,
        StStat,
        StDrop
    } state_e;

    // Synchronisers and edge detection
    logic [SYNC_STAGES-1:0] ncs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   ncs_prev_q, sck_prev_q;
    logic                   ncs_s, sck_s, mosi_s;
    logic                   ncs_fall, ncs_rise, sck_rise, sck_fall;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_sr_q;
    logic        byte_done_q;
    logic [7:0]  miso_sr_q;
    logic [3:0]  ch_q;
    logic        cfg_seen_q;
    logic [NUM_CHANNELS-1:0] out_en_q;
    logic        buffer_oe_q;
    logic        ovf_q, ovf_d;
    logic        bad_q, bad_d;

    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [ChW+7:0]    mem [FIFO_DEPTH];
    logic              fifo_full, fifo_empty;
    logic              push, pop, push_ok, overflow;

    logic              in_frame;
    logic [1:0]        hdr_op;
    logic [3:0]        hdr_ch;
    logic              hdr_bad;
    logic              cfg_load;
    logic              stat_clr;
    logic [15:0]       cfg_ext;
    logic [7:0]        status_byte;

    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign ncs_fall = ncs_prev_q & ~ncs_s;
    assign ncs_rise = ~ncs_prev_q & ncs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;

    assign in_frame = (state_q != StIdle);
    assign hdr_op   = rx_sr_q[7:6];
    assign hdr_ch   = rx_sr_q[3:0];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign status_byte = {ovf_q, bad_q, fifo_full, fifo_empty, 4'b0000};

    // Bit 7 of the config byte is the buffer enable, never a channel enable
    assign cfg_ext = {9'b0, rx_sr_q[6:0]};

    always_comb begin
        state_d  = state_q;
        hdr_bad  = 1'b0;
        cfg_load = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ncs_fall) state_d = StHdr;
            end
            StHdr: begin
                if (byte_done_q) begin
                    unique case (hdr_op)
                        2'b10: begin
                            if (32'(hdr_ch) < NUM_CHANNELS) begin
                                state_d = StData;
                            end else begin
                                state_d = StDrop;
                                hdr_bad = 1'b1;
                            end
                        end
                        2'b01: state_d = StCfg;
                        2'b00: state_d = StStat;
                        default: begin
                            state_d = StDrop;
                            hdr_bad = 1'b1;
                        end
                    endcase
                end
            end
            StData: push = byte_done_q;
            StCfg:  cfg_load = byte_done_q && !cfg_seen_q;
            StStat: ;
            StDrop: ;
            default: state_d = StIdle;
        endcase
        if (ncs_rise) state_d = StIdle;
    end

    assign stat_clr = (state_q == StStat) && ncs_rise;
    assign pop      = !fifo_empty && out_ready;
    assign push_ok  = push && (!fifo_full || pop);
    assign overflow = push && fifo_full && !pop;

    // A sticky set in the same cycle as a STAT clear must win
    always_comb begin
        ovf_d = ovf_q;
        bad_d = bad_q;
        if (stat_clr) begin
            ovf_d = 1'b0;
            bad_d = 1'b0;
        end
        if (overflow) ovf_d = 1'b1;
        if (hdr_bad)  bad_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ncs_sync_q  <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ncs_prev_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            byte_done_q <= 1'b0;
            miso_sr_q   <= '0;
            ch_q        <= '0;
            cfg_seen_q  <= 1'b0;
            out_en_q    <= '0;
            buffer_oe_q <= 1'b0;
            ovf_q       <= 1'b0;
            bad_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi_nCS};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            ncs_prev_q  <= ncs_s;
            sck_prev_q  <= sck_s;
            state_q     <= state_d;
            byte_done_q <= in_frame && sck_rise && (bit_cnt_q == 3'd7);

            if (state_q == StIdle) begin
                if (ncs_fall) begin
                    bit_cnt_q  <= '0;
                    miso_sr_q  <= status_byte;
                    cfg_seen_q <= 1'b0;
                end
            end else begin
                if (sck_rise) begin
                    rx_sr_q   <= {rx_sr_q[6:0], mosi_s};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (sck_fall) miso_sr_q <= {miso_sr_q[6:0], 1'b0};
            end

            if (state_q == StHdr && byte_done_q) ch_q <= hdr_ch;

            if (cfg_load) begin
                out_en_q    <= cfg_ext[NUM_CHANNELS-1:0];
                buffer_oe_q <= rx_sr_q[7];
                cfg_seen_q  <= 1'b1;
            end

            ovf_q <= ovf_d;
            bad_q <= bad_d;

            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr_q[AW-1:0]] <= {ch_q[ChW-1:0], rx_sr_q};
    end

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? mem[rd_ptr_q[AW-1:0]][7:0] : 8'h00;
    assign out_chan  = out_valid ? mem[rd_ptr_q[AW-1:0]][ChW+7:8] : '0;
    assign out_en    = out_en_q;
    assign buffer_oe = buffer_oe_q;
    assign status    = {bad_q, ovf_q, out_valid};
    assign spi_miso  = in_frame & miso_sr_q[7];

endmodule

// File: tb/tb_spi_chan_mux.sv
// Directed bench for spi_chan_mux: expected FIFO pops are queued by the stimulus and checked by an
// independent monitor; register and MISO values are compared against hand-computed constants.
module tb_spi_chan_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_nCS, spi_sck, spi_mosi, spi_miso;
    logic [7:0] out_data;
    logic [1:0] out_chan;
    logic       out_valid, out_ready;
    logic [3:0] out_en;
    logic       buffer_oe;
    logic [2:0] status;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    spi_chan_mux #(
        .NUM_CHANNELS(4),
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_nCS  (spi_nCS),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .out_data (out_data),
        .out_chan (out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_en   (out_en),
        .buffer_oe(buffer_oe),
        .status   (status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen here completes at the following rising edge
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got {%0d,%02h}, expected no entry", out_chan, out_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({out_chan, out_data} !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got {%0d,%02h}, expected {%0d,%02h}",
                             out_chan, out_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    task automatic spi_begin();
        @(negedge clk);
        spi_nCS = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        spi_nCS = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        reset     = 1'b1;
        spi_nCS   = 1'b1;
        spi_sck   = 1'b0;
        spi_mosi  = 1'b0;
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_status", status, 3'b000);
        check("rst_out_en", out_en, 4'h0);
        check("rst_miso", spi_miso, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // CFG frame
        spi_begin();
        spi_bits(8'h40, 8, rx);
        check("cfg_miso_byte0", rx, 8'h10);
        spi_bits(8'h85, 8, rx);
        spi_bits(8'h12, 8, rx);
        spi_end();
        check("cfg_out_en", out_en, 4'b0101);
        check("cfg_buffer_oe", buffer_oe, 1);

        // DATA frame held, then drained
        spi_begin();
        spi_bits(8'h82, 8, rx);
        spi_bits(8'hAA, 8, rx);
        exp_q.push_back({2'd2, 8'hAA});
        spi_bits(8'h55, 8, rx);
        exp_q.push_back({2'd2, 8'h55});
        spi_end();
        check("data_valid", out_valid, 1);
        check("data_head", out_data, 8'hAA);
        check("data_chan", out_chan, 2'd2);
        set_ready(1'b1);
        wait_drain("data_drain", 20);
        repeat (2) @(negedge clk);
        check("data_empty", out_valid, 0);

        // Overflow: 17 bytes into 16 entries
        set_ready(1'b0);
        spi_begin();
        spi_bits(8'h81, 8, rx);
        for (int i = 0; i < 17; i++) begin
            spi_bits(8'h10 + 8'(i), 8, rx);
            if (i < 16) exp_q.push_back({2'd1, 8'h10 + 8'(i)});
        end
        spi_end();
        check("ovf_status", status, 3'b011);
        spi_begin();
        spi_bits(8'h81, 8, rx);
        spi_end();
        check("ovf_miso_byte0", rx, 8'hA0);
        set_ready(1'b1);
        wait_drain("ovf_drain", 40);
        repeat (2) @(negedge clk);
        check("ovf_sticky_kept", status, 3'b010);

        // Bad headers with ready high: any push would show as an unexpected pop
        spi_begin();
        spi_bits(8'h87, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_end();
        check("bad_ch_status", status, 3'b110);
        spi_begin();
        spi_bits(8'hC0, 8, rx);
        spi_bits(8'h22, 8, rx);
        spi_end();
        check("bad_op_status", status, 3'b110);
        check("cfg_unchanged", out_en, 4'b0101);
        spi_begin();
        spi_bits(8'h00, 8, rx);
        check("stat_miso_byte0", rx, 8'hD0);
        spi_bits(8'hFF, 8, rx);
        check("stat_miso_byte1", rx, 8'h00);
        spi_end();
        check("stat_cleared", status, 3'b000);

        // Partial byte discarded
        set_ready(1'b0);
        spi_begin();
        spi_bits(8'h83, 8, rx);
        spi_bits(8'hC3, 8, rx);
        exp_q.push_back({2'd3, 8'hC3});
        spi_bits(8'hFF, 5, rx);
        spi_end();
        check("part_head", out_data, 8'hC3);
        check("part_chan", out_chan, 2'd3);
        check("part_status", status, 3'b001);
        set_ready(1'b1);
        wait_drain("part_drain", 20);
        spi_begin();
        spi_bits(8'h80, 8, rx);
        spi_bits(8'h5A, 8, rx);
        exp_q.push_back({2'd0, 8'h5A});
        spi_end();
        wait_drain("part_next_drain", 20);

        // Reset in the middle of a frame
        set_ready(1'b0);
        spi_begin();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'h77, 8, rx);
        spi_end();
        check("pre_rst_valid", out_valid, 1);
        spi_begin();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'h99, 4, rx);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 8'h00);
        check("mid_rst_out_en", out_en, 4'h0);
        check("mid_rst_oe", buffer_oe, 0);
        check("mid_rst_status", status, 3'b000);
        check("mid_rst_miso", spi_miso, 0);
        spi_bits(8'h99, 4, rx);
        spi_end();
        spi_begin();
        spi_bits(8'h40, 8, rx);
        check("post_rst_miso_byte0", rx, 8'h10);
        spi_bits(8'h03, 8, rx);
        spi_end();
        check("post_rst_out_en", out_en, 4'b0011);
        check("post_rst_oe", buffer_oe, 0);
        check("post_rst_valid", out_valid, 0);
        set_ready(1'b1);
        repeat (10) @(negedge clk);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
